// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - Tomasulo reservation station for the ALU with execute stage and CDB output
//
// Purpose: buffers issued ALU/branch/jump ops, resolves pending operands by
// snooping the ALU CDB (own output) and the LSB CDB, dispatches the lowest
// ready entry each cycle into a registered execute stage that drives the
// combinational ALU, and registers the ALU outputs onto the ALU CDB.
//
// Ports:
//   clk_in, rst_in, rdy_in, clear_in    clock, sync reset, global ready, flush
//   full_out                            no free entry in the current state
//   issue_*_in                          issue request and decoded operands
//   alu_*_out                           execute stage driving the ALU
//   alu_*_in                            combinational ALU results
//   lsb_cdb_*_in                        LSB broadcast snooped for wakeup
//   cdb_*_out                           ALU broadcast to ROB and stations
module alu_reservation_station #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,
  output logic                 full_out,
  input  logic                 issue_valid_in,
  input  logic [5:0]           issue_inst_name_in,
  input  logic [31:0]          issue_V1_in,
  input  logic                 issue_Q1_pending_in,
  input  logic [ROB_WIDTH-1:0] issue_Q1_in,
  input  logic [31:0]          issue_V2_in,
  input  logic                 issue_Q2_pending_in,
  input  logic [ROB_WIDTH-1:0] issue_Q2_in,
  input  logic [31:0]          issue_imm_in,
  input  logic [31:0]          issue_pc_in,
  input  logic [ROB_WIDTH-1:0] issue_rob_id_in,
  output logic [5:0]           alu_inst_name_out,
  output logic [31:0]          alu_V1_out,
  output logic [31:0]          alu_V2_out,
  output logic [31:0]          alu_imm_out,
  output logic [31:0]          alu_pc_out,
  input  logic [31:0]          alu_result_in,
  input  logic [31:0]          alu_target_pc_in,
  input  logic                 alu_jump_in,
  input  logic                 alu_valid_in,
  input  logic                 lsb_cdb_valid_in,
  input  logic [ROB_WIDTH-1:0] lsb_cdb_rob_id_in,
  input  logic [31:0]          lsb_cdb_result_in,
  output logic                 cdb_valid_out,
  output logic [ROB_WIDTH-1:0] cdb_rob_id_out,
  output logic [31:0]          cdb_result_out,
  output logic [31:0]          cdb_target_pc_out,
  output logic                 cdb_jump_out
);

  localparam int         IDX_W = $clog2(RS_SIZE);
  localparam logic [5:0] NOP   = 6'd0;

  // Station entries
  logic [RS_SIZE-1:0]   e_valid;
  logic [RS_SIZE-1:0]   e_q1p;
  logic [RS_SIZE-1:0]   e_q2p;
  logic [5:0]           e_op  [RS_SIZE];
  logic [31:0]          e_v1  [RS_SIZE];
  logic [31:0]          e_v2  [RS_SIZE];
  logic [ROB_WIDTH-1:0] e_q1  [RS_SIZE];
  logic [ROB_WIDTH-1:0] e_q2  [RS_SIZE];
  logic [31:0]          e_imm [RS_SIZE];
  logic [31:0]          e_pc  [RS_SIZE];
  logic [ROB_WIDTH-1:0] e_rob [RS_SIZE];

  // Execute stage
  logic                 ex_valid;
  logic [ROB_WIDTH-1:0] ex_rob;

  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] ready_idx;
  logic             ready_found;
  logic [31:0]      iss_v1;
  logic [31:0]      iss_v2;
  logic             iss_q1p;
  logic             iss_q2p;

  assign full_out = &e_valid;

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    free_idx    = '0;
    ready_idx   = '0;
    ready_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!e_valid[i]) begin
        free_idx = IDX_W'(i);
      end
      if (e_valid[i] && !e_q1p[i] && !e_q2p[i]) begin
        ready_found = 1'b1;
        ready_idx   = IDX_W'(i);
      end
    end
  end

  // Issue-time bypass: an operand whose producer is broadcasting right now
  // would otherwise miss that broadcast and wait forever.
  always_comb begin
    iss_v1  = issue_V1_in;
    iss_q1p = issue_Q1_pending_in;
    iss_v2  = issue_V2_in;
    iss_q2p = issue_Q2_pending_in;
    if (issue_Q1_pending_in) begin
      if (cdb_valid_out && cdb_rob_id_out == issue_Q1_in) begin
        iss_v1  = cdb_result_out;
        iss_q1p = 1'b0;
      end else if (lsb_cdb_valid_in && lsb_cdb_rob_id_in == issue_Q1_in) begin
        iss_v1  = lsb_cdb_result_in;
        iss_q1p = 1'b0;
      end
    end
    if (issue_Q2_pending_in) begin
      if (cdb_valid_out && cdb_rob_id_out == issue_Q2_in) begin
        iss_v2  = cdb_result_out;
        iss_q2p = 1'b0;
      end else if (lsb_cdb_valid_in && lsb_cdb_rob_id_in == issue_Q2_in) begin
        iss_v2  = lsb_cdb_result_in;
        iss_q2p = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && clear_in)) begin
      e_valid           <= '0;
      ex_valid          <= 1'b0;
      ex_rob            <= '0;
      alu_inst_name_out <= NOP;
      alu_V1_out        <= '0;
      alu_V2_out        <= '0;
      alu_imm_out       <= '0;
      alu_pc_out        <= '0;
      cdb_valid_out     <= 1'b0;
      cdb_rob_id_out    <= '0;
      cdb_result_out    <= '0;
      cdb_target_pc_out <= '0;
      cdb_jump_out      <= 1'b0;
    end else if (rdy_in) begin
      // Wakeup: the cleared pending bit is only seen by select next cycle.
      for (int i = 0; i < RS_SIZE; i++) begin
        if (e_valid[i] && e_q1p[i]) begin
          if (cdb_valid_out && cdb_rob_id_out == e_q1[i]) begin
            e_v1[i]  <= cdb_result_out;
            e_q1p[i] <= 1'b0;
          end else if (lsb_cdb_valid_in && lsb_cdb_rob_id_in == e_q1[i]) begin
            e_v1[i]  <= lsb_cdb_result_in;
            e_q1p[i] <= 1'b0;
          end
        end
        if (e_valid[i] && e_q2p[i]) begin
          if (cdb_valid_out && cdb_rob_id_out == e_q2[i]) begin
            e_v2[i]  <= cdb_result_out;
            e_q2p[i] <= 1'b0;
          end else if (lsb_cdb_valid_in && lsb_cdb_rob_id_in == e_q2[i]) begin
            e_v2[i]  <= lsb_cdb_result_in;
            e_q2p[i] <= 1'b0;
          end
        end
      end

      // Issue targets a currently free entry, dispatch a currently valid one,
      // so the two never touch the same index.
      if (issue_valid_in && !full_out) begin
        e_valid[free_idx] <= 1'b1;
        e_op[free_idx]    <= issue_inst_name_in;
        e_v1[free_idx]    <= iss_v1;
        e_q1p[free_idx]   <= iss_q1p;
        e_q1[free_idx]    <= issue_Q1_in;
        e_v2[free_idx]    <= iss_v2;
        e_q2p[free_idx]   <= iss_q2p;
        e_q2[free_idx]    <= issue_Q2_in;
        e_imm[free_idx]   <= issue_imm_in;
        e_pc[free_idx]    <= issue_pc_in;
        e_rob[free_idx]   <= issue_rob_id_in;
      end

      if (ready_found) begin
        e_valid[ready_idx] <= 1'b0;
        ex_valid           <= 1'b1;
        ex_rob             <= e_rob[ready_idx];
        alu_inst_name_out  <= e_op[ready_idx];
        alu_V1_out         <= e_v1[ready_idx];
        alu_V2_out         <= e_v2[ready_idx];
        alu_imm_out        <= e_imm[ready_idx];
        alu_pc_out         <= e_pc[ready_idx];
      end else begin
        ex_valid          <= 1'b0;
        alu_inst_name_out <= NOP;
      end

      // The ALU flags every op it recognises; an unrecognised op is dropped
      // rather than broadcasting garbage to the ROB.
      if (ex_valid && alu_valid_in) begin
        cdb_valid_out     <= 1'b1;
        cdb_rob_id_out    <= ex_rob;
        cdb_result_out    <= alu_result_in;
        cdb_target_pc_out <= alu_target_pc_in;
        cdb_jump_out      <= alu_jump_in;
      end else begin
        cdb_valid_out <= 1'b0;
      end
    end
  end

endmodule
